// File: rtl/timer_pkg.sv
// Shared definitions for the microwave timer chain: key codes, FSM states and the BCD digit type.
package timer_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_START = 4'd11;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_LOAD,
    ST_RUN,
    ST_PAUSE
  } state_t;

endpackage

// File: rtl/time_entry_loader_if.sv
// Keypad, door and counter-chain signals seen by the time entry loader.
interface time_entry_if;
  import timer_pkg::*;

  logic       en;
  logic       key_valid;
  logic [3:0] key_code;
  logic       door_closed;
  logic       timer_zero;
  bcd_t       min_ones;
  bcd_t       sec_tens;
  bcd_t       sec_ones;
  logic       loadn;
  logic       cnt_en;
  logic [1:0] digit_count;
  logic       entry_err;
  logic       done;

  modport master (
    output en, key_valid, key_code, door_closed, timer_zero,
    input  min_ones, sec_tens, sec_ones, loadn, cnt_en, digit_count, entry_err, done
  );

  modport slave (
    input  en, key_valid, key_code, door_closed, timer_zero,
    output min_ones, sec_tens, sec_ones, loadn, cnt_en, digit_count, entry_err, done
  );

endinterface

// File: rtl/time_normalize.sv
// Folds an M:SS entry with seconds-tens above 5 into the next minute, saturating at 9:59.
module time_normalize
  import timer_pkg::*;
(
  input  bcd_t min_i,
  input  bcd_t tens_i,
  input  bcd_t ones_i,
  output bcd_t min_o,
  output bcd_t tens_o,
  output bcd_t ones_o,
  output logic is_zero_o
);

  logic       carry;
  logic [4:0] minSum;

  always_comb begin
    is_zero_o = (min_i == 4'd0) && (tens_i == 4'd0) && (ones_i == 4'd0);
    carry     = (tens_i > 4'd5);
    minSum    = {1'b0, min_i} + {4'd0, carry};
    min_o     = minSum[3:0];
    tens_o    = carry ? (tens_i - 4'd6) : tens_i;
    ones_o    = ones_i;
    if (minSum > 5'd9) begin
      min_o  = 4'd9;
      tens_o = 4'd5;
      ones_o = 4'd9;
    end
  end

endmodule

// File: rtl/time_entry_loader.sv
// Keypad-side producer for the countdown chain: collects M:SS digits, loads the counters, gates counting.
module time_entry_loader
  import timer_pkg::*;
#(
  parameter logic [3:0] QS_TENS    = 4'd3,
  parameter logic [3:0] QS_ONES    = 4'd0,
  parameter int         MAX_DIGITS = 3
) (
  input logic         clk,
  input logic         clrn,
  time_entry_if.slave bus
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  state_t     state_q;
  bcd_t       minOnes_q, secTens_q, secOnes_q;
  logic [1:0] digitCount_q;
  logic       loadn_q, cntEn_q, entryErr_q, done_q, firstRun_q;

  bcd_t normMin, normTens, normOnes;
  bcd_t minOnes_d, secTens_d, secOnes_d;
  logic isZero;

  logic isDigit, isClear, isStart;

  assign isDigit = bus.key_valid && (bus.key_code <= 4'd9);
  assign isClear = bus.key_valid && (bus.key_code == KEY_CLEAR);
  assign isStart = bus.key_valid && (bus.key_code == KEY_START);

  time_normalize u_norm (
    .min_i     (minOnes_q),
    .tens_i    (secTens_q),
    .ones_i    (secOnes_q),
    .min_o     (normMin),
    .tens_o    (normTens),
    .ones_o    (normOnes),
    .is_zero_o (isZero)
  );

  // An empty or all-zero entry falls back to the quick-start time.
  assign minOnes_d = isZero ? 4'd0    : normMin;
  assign secTens_d = isZero ? QS_TENS : normTens;
  assign secOnes_d = isZero ? QS_ONES : normOnes;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= ST_IDLE;
      minOnes_q    <= '0;
      secTens_q    <= '0;
      secOnes_q    <= '0;
      digitCount_q <= '0;
      loadn_q      <= 1'b1;
      cntEn_q      <= 1'b0;
      entryErr_q   <= 1'b0;
      done_q       <= 1'b0;
      firstRun_q   <= 1'b0;
    end else begin
      entryErr_q <= 1'b0;
      done_q     <= 1'b0;
      if (bus.en) begin
        case (state_q)
          ST_IDLE, ST_ENTRY: begin
            if (isClear) begin
              minOnes_q    <= '0;
              secTens_q    <= '0;
              secOnes_q    <= '0;
              digitCount_q <= '0;
              cntEn_q      <= 1'b0;
              state_q      <= ST_IDLE;
            end else if (isStart) begin
              if (!bus.door_closed) begin
                entryErr_q <= 1'b1;
              end else begin
                minOnes_q    <= minOnes_d;
                secTens_q    <= secTens_d;
                secOnes_q    <= secOnes_d;
                digitCount_q <= '0;
                loadn_q      <= 1'b0;
                cntEn_q      <= 1'b0;
                state_q      <= ST_LOAD;
              end
            end else if (isDigit && (digitCount_q < MAX_CNT)) begin
              minOnes_q    <= secTens_q;
              secTens_q    <= secOnes_q;
              secOnes_q    <= bus.key_code;
              digitCount_q <= digitCount_q + 2'd1;
              state_q      <= ST_ENTRY;
            end
          end
          ST_LOAD: begin
            loadn_q    <= 1'b1;
            cntEn_q    <= 1'b1;
            firstRun_q <= 1'b1;
            state_q    <= ST_RUN;
          end
          // The counters were only just loaded, so their zero flag is stale for one cycle.
          ST_RUN: begin
            firstRun_q <= 1'b0;
            if (!bus.door_closed) begin
              cntEn_q <= 1'b0;
              state_q <= ST_PAUSE;
            end else if (isClear) begin
              minOnes_q    <= '0;
              secTens_q    <= '0;
              secOnes_q    <= '0;
              digitCount_q <= '0;
              cntEn_q      <= 1'b0;
              state_q      <= ST_IDLE;
            end else if (bus.timer_zero && !firstRun_q) begin
              minOnes_q <= '0;
              secTens_q <= '0;
              secOnes_q <= '0;
              cntEn_q   <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= ST_IDLE;
            end
          end
          ST_PAUSE: begin
            if (isClear) begin
              minOnes_q    <= '0;
              secTens_q    <= '0;
              secOnes_q    <= '0;
              digitCount_q <= '0;
              cntEn_q      <= 1'b0;
              state_q      <= ST_IDLE;
            end else if (isStart) begin
              if (!bus.door_closed) begin
                entryErr_q <= 1'b1;
              end else begin
                cntEn_q <= 1'b1;
                state_q <= ST_RUN;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.min_ones    = minOnes_q;
  assign bus.sec_tens    = secTens_q;
  assign bus.sec_ones    = secOnes_q;
  assign bus.loadn       = loadn_q | ~bus.en;
  assign bus.cnt_en      = cntEn_q;
  assign bus.digit_count = digitCount_q;
  assign bus.entry_err   = entryErr_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_time_entry_loader.sv
// Directed bench for time_entry_loader with hand-computed expected values.
module tb_time_entry_loader;
  import timer_pkg::*;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  int   checkCount = 0;
  int   errorCount = 0;

  time_entry_if bus ();

  time_entry_loader #(
    .QS_TENS    (4'd3),
    .QS_ONES    (4'd0),
    .MAX_DIGITS (3)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] code);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic checkTime(input string tag, input int m, input int t, input int o);
    checkOutput({tag, ".min"},  int'(bus.min_ones), m);
    checkOutput({tag, ".tens"}, int'(bus.sec_tens), t);
    checkOutput({tag, ".ones"}, int'(bus.sec_ones), o);
  endtask

  initial begin
    bus.en          = 1'b1;
    bus.key_valid   = 1'b0;
    bus.key_code    = 4'd0;
    bus.door_closed = 1'b1;
    bus.timer_zero  = 1'b0;
    tick();
    tick();
    checkTime("reset", 0, 0, 0);
    checkOutput("reset.loadn", int'(bus.loadn), 1);
    checkOutput("reset.cnt_en", int'(bus.cnt_en), 0);
    checkOutput("reset.count", int'(bus.digit_count), 0);
    checkOutput("reset.err", int'(bus.entry_err), 0);
    checkOutput("reset.done", int'(bus.done), 0);
    clrn = 1'b1;
    tick();

    applyStimulus(4'd12);
    checkOutput("key12.count", int'(bus.digit_count), 0);

    // 1,3,0 START -> 1:30
    applyStimulus(4'd1);
    applyStimulus(4'd3);
    applyStimulus(4'd0);
    checkOutput("130.count", int'(bus.digit_count), 3);
    applyStimulus(KEY_START);
    checkOutput("130.loadn", int'(bus.loadn), 0);
    checkOutput("130.cnt_en_load", int'(bus.cnt_en), 0);
    checkTime("130", 1, 3, 0);
    checkOutput("130.count_load", int'(bus.digit_count), 0);
    tick();
    checkOutput("130.loadn_run", int'(bus.loadn), 1);
    checkOutput("130.cnt_en_run", int'(bus.cnt_en), 1);
    applyStimulus(KEY_CLEAR);
    checkOutput("clr_run.cnt_en", int'(bus.cnt_en), 0);
    checkTime("clr_run", 0, 0, 0);

    // 9,0 START -> 1:30
    applyStimulus(4'd9);
    applyStimulus(4'd0);
    applyStimulus(KEY_START);
    checkOutput("90.loadn", int'(bus.loadn), 0);
    checkTime("90", 1, 3, 0);
    tick();
    applyStimulus(KEY_CLEAR);

    // 9,9,9 START -> 9:59
    applyStimulus(4'd9);
    applyStimulus(4'd9);
    applyStimulus(4'd9);
    applyStimulus(KEY_START);
    checkTime("999", 9, 5, 9);
    tick();
    applyStimulus(KEY_CLEAR);

    // quick start, then 0,0 START
    applyStimulus(KEY_START);
    checkOutput("qs.loadn", int'(bus.loadn), 0);
    checkTime("qs", 0, 3, 0);
    tick();
    applyStimulus(KEY_CLEAR);
    applyStimulus(4'd0);
    applyStimulus(4'd0);
    checkOutput("00.count", int'(bus.digit_count), 2);
    applyStimulus(KEY_START);
    checkOutput("00.loadn", int'(bus.loadn), 0);
    checkTime("00", 0, 3, 0);
    tick();
    applyStimulus(KEY_CLEAR);

    // door opened during RUN, same cycle as digit 5
    applyStimulus(4'd1);
    applyStimulus(4'd3);
    applyStimulus(4'd0);
    applyStimulus(KEY_START);
    tick();
    bus.door_closed = 1'b0;
    applyStimulus(4'd5);
    checkOutput("pause.cnt_en", int'(bus.cnt_en), 0);
    checkTime("pause", 1, 3, 0);
    applyStimulus(KEY_START);
    checkOutput("pause.err", int'(bus.entry_err), 1);
    tick();
    checkOutput("pause.err_clr", int'(bus.entry_err), 0);
    bus.door_closed = 1'b1;
    tick();
    checkOutput("pause.no_resume", int'(bus.cnt_en), 0);
    applyStimulus(KEY_START);
    checkOutput("resume.cnt_en", int'(bus.cnt_en), 1);
    checkOutput("resume.loadn", int'(bus.loadn), 1);
    checkTime("resume", 1, 3, 0);
    tick();
    checkOutput("resume.loadn2", int'(bus.loadn), 1);
    applyStimulus(KEY_CLEAR);

    // timer_zero high from LOAD: masked once, then done
    applyStimulus(4'd2);
    bus.timer_zero = 1'b1;
    applyStimulus(KEY_START);
    tick();
    checkOutput("tz.first_cnt", int'(bus.cnt_en), 1);
    tick();
    checkOutput("tz.masked_done", int'(bus.done), 0);
    checkOutput("tz.masked_cnt", int'(bus.cnt_en), 1);
    tick();
    checkOutput("tz.done", int'(bus.done), 1);
    checkOutput("tz.cnt_en", int'(bus.cnt_en), 0);
    checkTime("tz", 0, 0, 0);
    bus.timer_zero = 1'b0;
    tick();
    checkOutput("tz.done_clr", int'(bus.done), 0);

    // fourth digit dropped, then CLEAR in ENTRY
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(4'd4);
    checkOutput("1234.count", int'(bus.digit_count), 3);
    checkTime("1234", 1, 2, 3);
    applyStimulus(KEY_CLEAR);
    checkOutput("clr_entry.count", int'(bus.digit_count), 0);
    checkTime("clr_entry", 0, 0, 0);

    // en=0 holds a pending LOAD
    applyStimulus(4'd4);
    applyStimulus(KEY_START);
    checkOutput("en.loadn_first", int'(bus.loadn), 0);
    bus.en = 1'b0;
    #1;
    checkOutput("en.loadn_gated", int'(bus.loadn), 1);
    tick();
    tick();
    checkOutput("en.hold_loadn", int'(bus.loadn), 1);
    checkOutput("en.hold_cnt", int'(bus.cnt_en), 0);
    bus.en = 1'b1;
    #1;
    checkOutput("en.loadn_resume", int'(bus.loadn), 0);
    tick();
    checkOutput("en.run_loadn", int'(bus.loadn), 1);
    checkOutput("en.run_cnt", int'(bus.cnt_en), 1);
    checkTime("en", 0, 0, 4);

    // async reset mid-RUN
    clrn = 1'b0;
    #1;
    checkOutput("rst.cnt_en", int'(bus.cnt_en), 0);
    checkOutput("rst.loadn", int'(bus.loadn), 1);
    checkTime("rst", 0, 0, 0);
    #1;
    clrn = 1'b1;
    tick();
    checkOutput("rst.after_cnt", int'(bus.cnt_en), 0);
    checkOutput("rst.after_loadn", int'(bus.loadn), 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
